// File: rtl/iter_divider.sv
// iter_divider: iterative integer divider for DIV/DIVU/REM/REMU.
// Restoring shift-subtract with BITS_PER_CYCLE quotient bits per cycle.
// A divide by zero or a signed overflow can optionally finish one cycle
// after accept (EARLY_OUT).
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   in_vld/in_rdy            request handshake; opa, opb, op latched on accept
//   opa, opb                 dividend, divisor
//   op                       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   flush                    squash any in-flight operation
//   out_vld/out_rdy          result handshake; out_res holds while stalled
//   busy                     unit not idle
//
// state  | meaning
// IDLE   | waiting for a request; only state where in_rdy can be high
// PREP   | take magnitudes, record result signs, load iteration counter
// ITER   | BITS_PER_CYCLE restoring steps per cycle, counter counts down
// FIX    | apply signs, pick quotient or remainder into the result register
// DONE   | out_vld high until the consumer takes the result
module iter_divider #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int EARLY_OUT      = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_vld,
   output logic            in_rdy,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] opb,
   input  logic [1:0]      op,
   input  logic            flush,
   output logic            out_vld,
   input  logic            out_rdy,
   output logic [XLEN-1:0] out_res,
   output logic            busy
);

   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d;
   logic [1:0]      op_q, op_d;
   logic [XLEN-1:0] quo_q, quo_d, dvs_q, dvs_d;
   logic [XLEN:0]   rem_q, rem_d;
   logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic            spec_q, spec_d;
   logic [XLEN-1:0] res_q, res_d;

   logic [XLEN:0]   it_rem;
   logic [XLEN-1:0] it_quo;
   logic            sign_a, sign_b, accept, in_spec;
   logic [XLEN-1:0] quo_fix, rem_fix;

   // Divide by zero and DIV/REM overflow; their results do not come out of
   // the sign-magnitude datapath correctly, so they are produced directly.
   function automatic logic is_special(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                       input logic [1:0] o);
      return (b == '0) || (!o[0] && (a == MIN_S) && (b == '1));
   endfunction

   function automatic logic [XLEN-1:0] special_res(input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b,
                                                   input logic [1:0] o);
      if (o[1]) return (b == '0) ? a : '0;
      return (b == '0) ? '1 : MIN_S;
   endfunction

   assign in_rdy  = (state_q == S_IDLE) && !flush && rst;
   assign accept  = in_vld && in_rdy;
   assign in_spec = is_special(opa, opb, op);
   assign out_vld = (state_q == S_DONE);
   assign out_res = res_q;
   assign busy    = (state_q != S_IDLE);

   assign sign_a  = !op_q[0] && a_q[XLEN-1];
   assign sign_b  = !op_q[0] && b_q[XLEN-1];
   assign quo_fix = neg_quo_q ? -quo_q : quo_q;
   assign rem_fix = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

   // The dividend shifts out of quo's top while quotient bits shift in below.
   always_comb begin
      it_rem = rem_q;
      it_quo = quo_q;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         it_rem = {it_rem[XLEN-1:0], it_quo[XLEN-1]};
         it_quo = {it_quo[XLEN-2:0], 1'b0};
         if (it_rem >= {1'b0, dvs_q}) begin
            it_rem    = it_rem - {1'b0, dvs_q};
            it_quo[0] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      spec_d    = spec_q;
      res_d     = res_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               a_d    = opa;
               b_d    = opb;
               op_d   = op;
               spec_d = in_spec;
               if ((EARLY_OUT != 0) && in_spec) begin
                  res_d   = special_res(opa, opb, op);
                  state_d = S_DONE;
               end else begin
                  state_d = S_PREP;
               end
            end
         end
         S_PREP: begin
            quo_d     = sign_a ? -a_q : a_q;
            dvs_d     = sign_b ? -b_q : b_q;
            rem_d     = '0;
            neg_quo_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            cnt_d     = CW'(N);
            state_d   = S_ITER;
         end
         S_ITER: begin
            quo_d = it_quo;
            rem_d = it_rem;
            cnt_d = cnt_q - CW'(1);
            if (cnt_d == '0) state_d = S_FIX;
         end
         S_FIX: begin
            if (spec_q) res_d = special_res(a_q, b_q, op_q);
            else        res_d = op_q[1] ? rem_fix : quo_fix;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_rdy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // A squashed operation must not disturb the held result.
      if (flush) begin
         state_d = S_IDLE;
         res_d   = res_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         spec_q    <= 1'b0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         spec_q    <= spec_d;
         res_q     <= res_d;
      end
   end

endmodule
